// File: rtl/mux_serializer_8b_pkg.sv
// Shared types and constants for the 8-bit word serializer.
// Select start/end points depend on the configured bit order.
package serializer_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
    return msb_first ? SEL_W'(WORD_W - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_end(input bit msb_first);
    return msb_first ? '0 : SEL_W'(WORD_W - 1);
  endfunction

endpackage

// File: rtl/mux_serializer_8b_if.sv
// Word-in / bit-out handshake bundle of the serializer.
// master: word producer and bit consumer; slave: the serializer.
interface mux_serializer_8b_if;
  import serializer_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              out_bit;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_bit,
    input  out_valid,
    input  out_last,
    input  sel,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_bit,
    output out_valid,
    output out_last,
    output sel,
    output busy
  );

endinterface

// File: rtl/mux_serializer_8b_mux.sv
// Plain 8:1 bit mux over the held word.
// Purely combinational; select comes from the serializer FSM.
module mux_8to1
  import serializer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  assign y = a[sel];

endmodule

// File: rtl/mux_serializer_8b.sv
// Parallel-in serial-out stage: active word plus one pending word,
// stepping an 8:1 mux select with an optional even-parity tail.
module mux_serializer_8b
  import serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b0
) (
  input logic clk,
  input logic rst,
  mux_serializer_8b_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_START = sel_start(MSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_END   = sel_end(MSB_FIRST);

  state_t            state;
  logic [WORD_W-1:0] active_word;
  logic [WORD_W-1:0] pending_word;
  logic              pending_full;
  logic              valid_q;
  logic              last_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_next;
  logic              data_bit;
  logic              accept;
  logic              xfer;
  logic              done;
  logic              load_direct;
  logic              at_end;

  assign bus.in_ready = !pending_full && !rst;

  assign accept      = bus.in_valid && bus.in_ready;
  assign xfer        = valid_q && bus.out_ready;
  assign done        = xfer && last_q;
  assign load_direct = accept && (state == IDLE || done);
  assign at_end      = (sel_q == SEL_END);

  assign sel_next = MSB_FIRST ? sel_q - SEL_W'(1)
                              : sel_q + SEL_W'(1);

  mux_8to1 u_mux (
    .a   (active_word),
    .sel (sel_q),
    .y   (data_bit)
  );

  assign bus.out_bit   = (state == PARITY) ? ^active_word
                                           : data_bit;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state != IDLE) || pending_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      active_word  <= '0;
      pending_word <= '0;
      pending_full <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      sel_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            active_word <= bus.in_data;
            state       <= SHIFT;
            valid_q     <= 1'b1;
            last_q      <= 1'b0;
            sel_q       <= SEL_START;
          end
        end
        SHIFT: begin
          if (xfer && !at_end) begin
            sel_q  <= sel_next;
            last_q <= !PARITY_EN && (sel_next == SEL_END);
          end else if (xfer && PARITY_EN) begin
            state  <= PARITY;
            last_q <= 1'b1;
          end
        end
        default: ;
      endcase

      // Word completion: pending word wins over a fresh input word
      if (done) begin
        unique case (1'b1)
          pending_full: begin
            active_word  <= pending_word;
            pending_full <= 1'b0;
            state        <= SHIFT;
            valid_q      <= 1'b1;
            last_q       <= 1'b0;
            sel_q        <= SEL_START;
          end
          accept: begin
            active_word <= bus.in_data;
            state       <= SHIFT;
            valid_q     <= 1'b1;
            last_q      <= 1'b0;
            sel_q       <= SEL_START;
          end
          default: begin
            state   <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        endcase
      end

      if (accept && !load_direct) begin
        pending_word <= bus.in_data;
        pending_full <= 1'b1;
      end
    end
  end

endmodule
